rcv_frame_buffer: RTL and testbench

- Receive-side frame buffer. Captures one byte-stream frame from the receive datapath into local storage and raises `rcv_data_ready` toward the CPU.
- The CPU reads the frame over an Avalon-MM slave.
- The CPU then releases the buffer through the `rcv_data_read_over` PIO output, which drives `read_over`; a rising edge on `read_over` re-arms capture.
- The block sits between the receive datapath and the NIOS2 `rcv_data_read_over` PIO.

---
 rtl/rcv_frame_buffer_pkg.sv | 19 +
 rtl/rcv_frame_ram.sv | 22 ++
 rtl/rcv_frame_buffer.sv | 159 +++++++++++++++
 tb/tb_rcv_frame_buffer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/rcv_frame_buffer_pkg.sv
// Shared types and register map for the receive frame buffer.
package rcv_pkg;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        READY   = 2'd1,
        DISCARD = 2'd2
    } rcv_state_e;

    localparam logic [1:0] RCV_ADDR_DATA = 2'd0;
    localparam logic [1:0] RCV_ADDR_STAT = 2'd1;
    localparam logic [1:0] RCV_ADDR_DROP = 2'd2;
    localparam logic [1:0] RCV_ADDR_PTR  = 2'd3;

    localparam int RCV_STAT_OVF_BIT   = 16;
    localparam int RCV_STAT_RDY_BIT   = 17;
    localparam int RCV_STAT_STATE_LSB = 18;

endpackage

// File: rtl/rcv_frame_ram.sv
// Frame storage: synchronous write, asynchronous read so CPU reads are zero-wait.
module rcv_frame_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rcv_frame_buffer.sv
// Captures one received frame, holds it for the CPU, and re-arms on a read_over rising edge.
module rcv_frame_buffer
    import rcv_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    input  logic        read_over,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read_n,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        rcv_data_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    rcv_state_e       state_q, state_d;
    logic [LEN_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [LEN_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0] length_q, length_d;
    logic             overflow_q, overflow_d;
    logic             mid_drop_q, mid_drop_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             read_over_q;
    logic             rcv_data_ready_q, rcv_data_ready_d;

    logic             rd_sel, wr_sel, rel, mem_we;
    logic [7:0]       mem_rdata;
    logic [LEN_W-1:0] ptr_wval;
    logic             unused_wdata;

    assign rd_sel       = chipselect & ~read_n;
    assign wr_sel       = chipselect & ~write_n;
    assign rel          = read_over & ~read_over_q;
    assign ptr_wval     = writedata[LEN_W-1:0];
    assign unused_wdata = ^writedata[31:LEN_W];

    rcv_frame_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (rx_data),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        length_d   = length_q;
        overflow_d = overflow_q;
        mid_drop_d = mid_drop_q;
        drop_cnt_d = drop_cnt_q;
        mem_we     = 1'b0;

        if (rd_sel && address == RCV_ADDR_DATA && rd_ptr_q < length_q)
            rd_ptr_d = rd_ptr_q + LEN_W'(1);
        if (wr_sel && address == RCV_ADDR_PTR)
            rd_ptr_d = (ptr_wval > length_q) ? length_q : ptr_wval;

        case (state_q)
            FILL: begin
                if (rx_valid) begin
                    if (wr_ptr_q < DEPTH_L) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + LEN_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                    if (rx_last) begin
                        length_d = (wr_ptr_q < DEPTH_L) ? wr_ptr_q + LEN_W'(1) : DEPTH_L;
                        state_d  = READY;
                    end
                end
            end
            READY: begin
                if (rx_valid) begin
                    if (rx_last) begin
                        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
                        mid_drop_d = 1'b0;
                    end else begin
                        mid_drop_d = 1'b1;
                    end
                end
                // Release sees this cycle's byte first, so a frame starting now is discarded.
                if (rel) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    length_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = mid_drop_d ? DISCARD : FILL;
                    mid_drop_d = 1'b0;
                end
            end
            DISCARD: begin
                if (rx_valid && rx_last) state_d = FILL;
            end
            default: state_d = FILL;
        endcase

        if (wr_sel && address == RCV_ADDR_DROP) drop_cnt_d = '0;

        rcv_data_ready_d = (state_d == READY);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= FILL;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            length_q         <= '0;
            overflow_q       <= 1'b0;
            mid_drop_q       <= 1'b0;
            drop_cnt_q       <= '0;
            read_over_q      <= 1'b0;
            rcv_data_ready_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            length_q         <= length_d;
            overflow_q       <= overflow_d;
            mid_drop_q       <= mid_drop_d;
            drop_cnt_q       <= drop_cnt_d;
            read_over_q      <= read_over;
            rcv_data_ready_q <= rcv_data_ready_d;
        end
    end

    always_comb begin
        readdata = '0;
        if (rd_sel) begin
            case (address)
                RCV_ADDR_DATA: if (rd_ptr_q < length_q) readdata[7:0] = mem_rdata;
                RCV_ADDR_STAT: begin
                    readdata[LEN_W-1:0]          = length_q;
                    readdata[RCV_STAT_OVF_BIT]   = overflow_q;
                    readdata[RCV_STAT_RDY_BIT]   = rcv_data_ready_q;
                    readdata[RCV_STAT_STATE_LSB +: 2] = state_q;
                end
                RCV_ADDR_DROP: readdata[7:0] = drop_cnt_q;
                default:       readdata[LEN_W-1:0] = rd_ptr_q;
            endcase
        end
    end

    assign rcv_data_ready = rcv_data_ready_q;

endmodule

// File: tb/tb_rcv_frame_buffer.sv
// Directed bench for rcv_frame_buffer; read responses are checked through a scoreboard queue.
module tb_rcv_frame_buffer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_last = 1'b0;
    logic        read_over = 1'b0;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        rcv_data_ready;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
        logic [31:0] mask;
    } exp_t;
    exp_t sb[$];

    localparam logic [31:0] LOW18 = 32'h0003_FFFF;
    localparam logic [31:0] STMSK = 32'h000C_0000;
    localparam logic [31:0] ALL   = 32'hFFFF_FFFF;

    rcv_frame_buffer #(.DEPTH(64)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_last(rx_last),
        .read_over(read_over),
        .address(address), .chipselect(chipselect), .read_n(read_n), .write_n(write_n),
        .writedata(writedata), .readdata(readdata), .rcv_data_ready(rcv_data_ready)
    );

    always #5 clk = ~clk;

    // Monitor: every read cycle presents a response; compare mid-cycle.
    always @(negedge clk) begin
        if (chipselect && !read_n) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read: readdata=%h, no expectation queued", readdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ((readdata & e.mask) !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h (mask %h), want %h", e.name, readdata & e.mask, e.mask, e.exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", n, act, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] e, input logic [31:0] m, input string n);
        chipselect = 1'b1; read_n = 1'b0; address = a;
        sb.push_back('{n, e, m});
        step();
        chipselect = 1'b0; read_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rx(input logic [7:0] d, input logic l);
        rx_valid = 1'b1; rx_data = d; rx_last = l;
        step();
        rx_valid = 1'b0; rx_last = 1'b0;
    endtask

    task automatic pulse_release();
        read_over = 1'b0; step();
        read_over = 1'b1; step();
    endtask

    initial begin
        step(); step();
        chk("reset_ready", {31'd0, rcv_data_ready}, 32'd0);
        chk("reset_readdata", readdata, 32'd0);
        reset_n = 1'b1;
        step();
        rd(2'd1, 32'h0, ALL, "reset_stat");
        rd(2'd2, 32'h0, ALL, "reset_drop");
        rd(2'd3, 32'h0, ALL, "reset_ptr");

        // 5-byte frame
        for (int i = 0; i < 4; i++) rx(8'h11 + 8'(i), 1'b0);
        chk("ready_before_last", {31'd0, rcv_data_ready}, 32'd0);
        rx(8'h15, 1'b1);
        chk("ready_after_last", {31'd0, rcv_data_ready}, 32'd1);
        rd(2'd1, 32'h0002_0005, LOW18, "stat_5B");
        rd(2'd1, 32'h0004_0000, STMSK, "state_ready");
        for (int i = 0; i < 5; i++) rd(2'd0, 32'h11 + i, ALL, "stream_5B");
        rd(2'd0, 32'h0, ALL, "read_past_len");
        rd(2'd3, 32'd5, ALL, "ptr_at_len");

        // pointer writes, ignored writes
        wr(2'd3, 32'd2);
        rd(2'd0, 32'h13, ALL, "ptr_wr2_data");
        wr(2'd3, 32'd9);
        rd(2'd3, 32'd5, ALL, "ptr_wr9_sat");
        rd(2'd0, 32'h0, ALL, "ptr_sat_data");
        wr(2'd1, 32'hFFFF_FFFF);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd1, 32'h0006_0005, ALL, "stat_after_ignored_wr");

        // release with no mid-frame traffic -> FILL
        read_over = 1'b1; step();
        chk("ready_after_rel", {31'd0, rcv_data_ready}, 32'd0);
        rd(2'd1, 32'h0, ALL, "stat_after_rel");

        // read_over held high: second frame stays READY
        rx(8'hA0, 1'b0); rx(8'hA1, 1'b0); rx(8'hA2, 1'b1);
        step(); step(); step();
        chk("held_high_no_rel", {31'd0, rcv_data_ready}, 32'd1);
        rd(2'd0, 32'hA0, ALL, "held_frame_b0");
        pulse_release();
        chk("rel_after_toggle", {31'd0, rcv_data_ready}, 32'd0);

        // 70-byte frame into 64-byte storage
        for (int i = 0; i < 70; i++) rx(8'(i), i == 69);
        rd(2'd1, 32'h0003_0040, LOW18, "stat_overflow");
        wr(2'd3, 32'd62);
        rd(2'd0, 32'd62, ALL, "ovf_b62");
        rd(2'd0, 32'd63, ALL, "ovf_b63");
        rd(2'd0, 32'd0, ALL, "ovf_b64_absent");

        // drops while READY, release mid-frame -> DISCARD
        read_over = 1'b0; step();
        rx(8'hC0, 1'b0); rx(8'hC1, 1'b1);
        rx(8'hC2, 1'b0); rx(8'hC3, 1'b1);
        rx(8'hC4, 1'b0); rx(8'hC5, 1'b0); rx(8'hC6, 1'b0);
        rd(2'd2, 32'd2, ALL, "drop_cnt_2");
        read_over = 1'b1; step();
        rd(2'd1, 32'h0008_0000, ALL, "stat_discard");
        rd(2'd2, 32'd2, ALL, "drop_kept_over_rel");
        rx(8'hC7, 1'b0); rx(8'hC8, 1'b1);
        rd(2'd1, 32'h0, ALL, "stat_fill_after_discard");
        rx(8'h31, 1'b0); rx(8'h32, 1'b0); rx(8'h33, 1'b1);
        rd(2'd1, 32'h0006_0003, ALL, "stat_clean_frame");
        rd(2'd0, 32'h31, ALL, "clean_b0");
        rd(2'd0, 32'h32, ALL, "clean_b1");
        rd(2'd0, 32'h33, ALL, "clean_b2");
        rd(2'd2, 32'd2, ALL, "discard_not_counted");

        // clear beats a simultaneous counting drop
        rx_valid = 1'b1; rx_data = 8'hEE; rx_last = 1'b1;
        chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'd0;
        step();
        rx_valid = 1'b0; rx_last = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        rd(2'd2, 32'd0, ALL, "clear_wins");
        rx(8'hEF, 1'b1);
        rd(2'd2, 32'd1, ALL, "drop_after_clear");

        // reset mid-frame
        pulse_release();
        rx(8'h41, 1'b0); rx(8'h42, 1'b0); rx(8'h43, 1'b0);
        reset_n = 1'b0;
        step();
        chk("rst_mid_ready", {31'd0, rcv_data_ready}, 32'd0);
        chk("rst_mid_readdata", readdata, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        rd(2'd1, 32'h0, ALL, "stat_after_reset");
        for (int i = 0; i < 4; i++) rx(8'h51 + 8'(i), i == 3);
        rd(2'd1, 32'h0006_0004, ALL, "stat_post_reset_frame");
        for (int i = 0; i < 4; i++) rd(2'd0, 32'h51 + i, ALL, "post_reset_stream");
        rd(2'd2, 32'd0, ALL, "drop_reset");

        step(); step();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
